sub_bytes_pipe: RTL and testbench

Parametrised, pipelined AES SubBytes engine. Each beat carries LANES bytes, and every byte is substituted through either the forward or the inverse AES S-box, selected per beat. Beats move through a valid/ready elastic pipeline with full backpressure and one beat per cycle sustained throughput. It sits between the round-key XOR stage and ShiftRows in the encrypt/decrypt datapath, and replaces the single-byte combinational lookup.

---
 rtl/aes_pkg.sv | 49 ++++
 rtl/sbox_lane_fi.sv | 21 ++
 rtl/sub_bytes_pipe.sv | 137 +++++++++++++
 tb/tb_sub_bytes_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES byte-substitution constants: forward and inverse FIPS-197 S-boxes
// and a shared lookup helper.
package aes_pkg;

    localparam int AES_BYTE_W = 8;

    localparam logic [7:0] SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] b, input logic inv);
        return inv ? SBOX_INV[b] : SBOX_FWD[b];
    endfunction

endpackage

// File: rtl/sbox_lane_fi.sv
// Single-byte combinational S-box; the inverse table exists only when
// SUPPORT_INV is set, otherwise the lane is forward-only.
module sbox_lane_fi
    import aes_pkg::*;
#(
    parameter bit SUPPORT_INV = 1'b1
) (
    input  logic [AES_BYTE_W-1:0] byte_i,
    input  logic                  inv_i,
    output logic [AES_BYTE_W-1:0] byte_o
);

    generate
        if (SUPPORT_INV) begin : g_fi
            assign byte_o = sbox_lookup(byte_i, inv_i);
        end else begin : g_fwd
            assign byte_o = SBOX_FWD[byte_i];
        end
    endgenerate

endmodule

// File: rtl/sub_bytes_pipe.sv
// Elastic valid/ready SubBytes pipeline: LANES parallel S-box lanes behind
// one or two register stages, full backpressure, one beat per cycle.
module sub_bytes_pipe
    import aes_pkg::*;
#(
    parameter int LANES       = 16,
    parameter int PIPE_STAGES = 2,
    parameter bit SUPPORT_INV = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_inv,
    input  logic [AES_BYTE_W*LANES-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_inv,
    output logic [AES_BYTE_W*LANES-1:0] out_data,
    output logic                        busy
);

    localparam int W = AES_BYTE_W * LANES;

    logic         en_p1;
    logic         lk_vld;
    logic         lk_inv;
    logic         lk_inv_eff;
    logic [W-1:0] lk_data;
    logic [W-1:0] sub_data;
    logic         p0_busy;

    logic         vld_p1_q, vld_p1_d;
    logic         inv_p1_q, inv_p1_d;
    logic [W-1:0] data_p1_q, data_p1_d;

    assign en_p1 = ~vld_p1_q | out_ready;

    // ---- stage 0: raw input register (two-stage build only) ----
    generate
        if (PIPE_STAGES == 2) begin : g_p0
            logic         en_p0;
            logic         vld_p0_q, vld_p0_d;
            logic         inv_p0_q, inv_p0_d;
            logic [W-1:0] data_p0_q, data_p0_d;

            assign en_p0 = ~vld_p0_q | en_p1;

            always_comb begin
                vld_p0_d  = vld_p0_q;
                inv_p0_d  = inv_p0_q;
                data_p0_d = data_p0_q;
                if (en_p0) begin
                    vld_p0_d = in_valid;
                    if (in_valid) begin
                        inv_p0_d  = in_inv;
                        data_p0_d = in_data;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_p0_q <= 1'b0;
                end else begin
                    vld_p0_q <= vld_p0_d;
                end
            end

            always_ff @(posedge clk) begin
                inv_p0_q  <= inv_p0_d;
                data_p0_q <= data_p0_d;
            end

            assign in_ready = en_p0 & ~rst;
            assign lk_vld   = vld_p0_q;
            assign lk_inv   = inv_p0_q;
            assign lk_data  = data_p0_q;
            assign p0_busy  = vld_p0_q;
        end else begin : g_p1_only
            assign in_ready = en_p1 & ~rst;
            assign lk_vld   = in_valid;
            assign lk_inv   = in_inv;
            assign lk_data  = in_data;
            assign p0_busy  = 1'b0;
        end
    endgenerate

    // ---- lookup: combinational, one lane per byte ----
    assign lk_inv_eff = SUPPORT_INV ? lk_inv : 1'b0;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            sbox_lane_fi #(
                .SUPPORT_INV(SUPPORT_INV)
            ) u_lane (
                .byte_i(lk_data[i*AES_BYTE_W +: AES_BYTE_W]),
                .inv_i (lk_inv_eff),
                .byte_o(sub_data[i*AES_BYTE_W +: AES_BYTE_W])
            );
        end
    endgenerate

    // ---- stage 1: output register ----
    always_comb begin
        vld_p1_d  = vld_p1_q;
        inv_p1_d  = inv_p1_q;
        data_p1_d = data_p1_q;
        if (en_p1) begin
            vld_p1_d = lk_vld;
            if (lk_vld) begin
                inv_p1_d  = lk_inv_eff;
                data_p1_d = sub_data;
            end
        end
    end

    // Output data is cleared on reset so a reset pipe presents all-zero outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            inv_p1_q  <= 1'b0;
            data_p1_q <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            inv_p1_q  <= inv_p1_d;
            data_p1_q <= data_p1_d;
        end
    end

    // Outputs are masked while rst is high so nothing leaks in the reset cycle itself.
    assign out_valid = vld_p1_q & ~rst;
    assign out_inv   = inv_p1_q & ~rst;
    assign out_data  = rst ? '0 : data_p1_q;
    assign busy      = (vld_p1_q | p0_busy) & ~rst;

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Scoreboard bench for sub_bytes_pipe: three builds (16 lanes/2 stages,
// 4 lanes/1 stage, 4 lanes forward-only) share one stimulus stream.
module tb_sub_bytes_pipe;

    typedef struct packed {
        logic [127:0] d;
        logic         inv;
        logic         lat;
        logic [31:0]  cyc;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_inv;
    logic [127:0] in_data;
    logic         out_ready;

    logic [2:0]   in_rdy;
    logic [2:0]   out_vld;
    logic [2:0]   out_invv;
    logic [2:0]   bsy;
    logic [127:0] out_d0;
    logic [31:0]  out_d1;
    logic [31:0]  out_d2;

    logic [127:0] cur_hand;
    logic         cur_use_hand;
    logic         chk_lat;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    ent_t sbq [3][$];

    logic [7:0] fwd_m [256];
    logic [7:0] inv_m [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sub_bytes_pipe #(.LANES(16), .PIPE_STAGES(2), .SUPPORT_INV(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[0]), .in_inv(in_inv),
        .in_data(in_data), .out_valid(out_vld[0]), .out_ready(out_ready), .out_inv(out_invv[0]),
        .out_data(out_d0), .busy(bsy[0]));

    sub_bytes_pipe #(.LANES(4), .PIPE_STAGES(1), .SUPPORT_INV(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[1]), .in_inv(in_inv),
        .in_data(in_data[31:0]), .out_valid(out_vld[1]), .out_ready(out_ready), .out_inv(out_invv[1]),
        .out_data(out_d1), .busy(bsy[1]));

    sub_bytes_pipe #(.LANES(4), .PIPE_STAGES(2), .SUPPORT_INV(1'b0)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[2]), .in_inv(in_inv),
        .in_data(in_data[31:0]), .out_valid(out_vld[2]), .out_ready(out_ready), .out_inv(out_invv[2]),
        .out_data(out_d2), .busy(bsy[2]));

    // GF(2^8) reference model of the S-box, independent of the RTL tables.
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    function automatic logic [7:0] model_fwd(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 1) ? 1 : 2;
    endfunction

    function automatic logic [127:0] exp_data(input int k, input logic [127:0] d, input logic inv);
        logic [127:0] r = '0;
        int lanes = (k == 0) ? 16 : 4;
        for (int i = 0; i < lanes; i++)
            r[i*8 +: 8] = (inv && k != 2) ? inv_m[d[i*8 +: 8]] : fwd_m[d[i*8 +: 8]];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic send(input logic [127:0] d, input logic inv, input logic [127:0] hexp, input logic use_hand);
        logic acc = 1'b0;
        in_valid = 1'b1; in_inv = inv; in_data = d;
        cur_hand = hexp; cur_use_hand = use_hand;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = in_rdy[0];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_accept_timeout", 128'(acc), 128'd1);
    endtask

    task automatic drain();
        int left = 1;
        for (int t = 0; t < 100 && left != 0; t++) begin
            @(negedge clk);
            left = sbq[0].size() + sbq[1].size() + sbq[2].size();
        end
        chk("drain_queues_empty", 128'(left), 128'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;
        logic [127:0] held;
        logic [127:0] got;
        logic         rdy;
        int           idx;
        ent_t         e;

        for (int x = 0; x < 256; x++) fwd_m[x] = model_fwd(8'(x));
        for (int x = 0; x < 256; x++) inv_m[fwd_m[x]] = 8'(x);

        rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b1;
        cur_hand = '0; cur_use_hand = 1'b0; chk_lat = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (rst) begin
                    for (int k = 0; k < 3; k++) sbq[k].delete();
                end else begin
                    for (int k = 0; k < 3; k++) begin
                        if (out_vld[k] && out_ready) begin
                            got = (k == 0) ? out_d0 : (k == 1) ? {96'b0, out_d1} : {96'b0, out_d2};
                            total++;
                            if (sbq[k].size() == 0) begin
                                bad++;
                                $display("FAIL unexpected_beat dut%0d got=%h", k, got);
                            end else begin
                                e = sbq[k].pop_front();
                                if (got !== e.d || out_invv[k] !== e.inv ||
                                    (e.lat && (cyc - int'(e.cyc)) != lat_of(k))) begin
                                    bad++;
                                    $display("FAIL beat dut%0d got=%h inv=%b lat=%0d want=%h inv=%b lat=%0d",
                                             k, got, out_invv[k], cyc - int'(e.cyc), e.d, e.inv, lat_of(k));
                                end
                            end
                        end
                        if (in_valid && in_rdy[k]) begin
                            e.d   = (k == 0 && cur_use_hand) ? cur_hand : exp_data(k, in_data, in_inv);
                            e.inv = in_inv && (k != 2);
                            e.lat = chk_lat;
                            e.cyc = 32'(cyc);
                            sbq[k].push_back(e);
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 128'(in_rdy), 128'd0);
        chk("rst_out_valid", 128'(out_vld), 128'd0);
        chk("rst_busy", 128'(bsy), 128'd0);
        chk("rst_out_data", out_d0, 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 128'(in_rdy), 128'd7);
        @(posedge clk); #1;

        // Directed FIPS-197 vectors, forward then inverse
        send(128'h00112233445566778899aabbccddeeff, 1'b0, 128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1);
        send(128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1, 128'h00112233445566778899aabbccddeeff, 1'b1);

        // Mixed modes back to back
        send({16{8'h00}}, 1'b0, {16{8'h63}}, 1'b1);
        send({16{8'h63}}, 1'b1, {16{8'h00}}, 1'b1);
        send({16{8'h53}}, 1'b0, {16{8'hed}}, 1'b1);
        send({16{8'h16}}, 1'b1, {16{8'hff}}, 1'b1);
        drain();

        // All byte values on every lane, forward then inverse
        for (int m = 0; m < 2; m++) begin
            for (int x = 0; x < 256; x++) begin
                for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(x + i * 17);
                send(d, m[0], '0, 1'b0);
            end
        end
        drain();

        // Backpressure: six stalled cycles with in_valid held high
        chk_lat = 1'b0;
        out_ready = 1'b0;
        idx = 0;
        held = '0;
        in_valid = 1'b1; in_inv = 1'b0; in_data = {16{8'h05}}; cur_use_hand = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            rdy = in_rdy[0];
            if (c == 3) held = out_d0;
            @(posedge clk); #1;
            if (rdy) begin
                idx++;
                in_data = {16{8'(idx * 16 + 5)}};
                in_inv  = idx[0];
            end
        end
        @(negedge clk);
        chk("bp_accepted", 128'(idx), 128'd2);
        chk("bp_in_ready_low", 128'(in_rdy[0]), 128'd0);
        chk("bp_out_hold", out_d0, held);
        chk("bp_out_valid", 128'(out_vld), 128'd7);
        @(posedge clk); #1;
        out_ready = 1'b1;
        while (idx < 8) begin
            send({16{8'(idx * 16 + 5)}}, idx[0], '0, 1'b0);
            idx++;
        end
        drain();
        chk_lat = 1'b1;

        // Reset with two beats in flight
        send({16{8'h3c}}, 1'b0, '0, 1'b0);
        send({16{8'ha7}}, 1'b1, '0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 128'(out_vld), 128'd0);
        chk("midrst_in_ready", 128'(in_rdy), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_out_valid", 128'(out_vld), 128'd0);
        chk("after_rst_busy", 128'(bsy), 128'd0);
        chk("after_rst_in_ready", 128'(in_rdy), 128'd7);
        chk("after_rst_out_data", out_d0, 128'd0);
        chk("after_rst_out_inv", 128'(out_invv), 128'd0);
        repeat (5) @(posedge clk);
        #1;

        // Recovery beat; forward-only build must return S(63)=fb with out_inv=0
        send({16{8'h63}}, 1'b1, {16{8'h00}}, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("fwd_only_inv_ignored", {96'b0, out_d2}, {96'b0, {4{8'hfb}}});
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
